// File: rtl/button_event_pkg.sv
// Shared constants for the button event scheduler: arbiter state encoding and
// default sizing parameters.
package button_event_pkg;

    localparam int unsigned N_CH_DEFAULT     = 4;
    localparam int unsigned PRESCALE_DEFAULT = 1000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/button_event_scheduler_rr_picker.sv
// Combinational circular priority search: lowest pending index at or after
// (last+1) mod N_CH.
module rr_picker
    import button_event_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT,
    parameter int unsigned W    = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] pending_i,
    input  logic [W-1:0]    last_i,
    output logic [W-1:0]    grant_o,
    output logic            any_o
);

    int unsigned idx;

    // Walk the offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        for (int unsigned k = N_CH; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N_CH;
            if (pending_i[idx]) begin
                grant_o = W'(idx);
            end
        end
        any_o = |pending_i;
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Samples N_CH level channels on a prescaled strobe, latches rising edges as
// pending events and offers them round-robin. Optional drop counter: BUTTON_EVENT_DROP_CNT_EN.
module button_event_scheduler
    import button_event_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEFAULT,
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         level,
    output logic                    update,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    input  logic                    evt_ready,
    output logic [N_CH-1:0]         pending,
    input  logic                    ovr_clr,
`ifdef BUTTON_EVENT_DROP_CNT_EN
    output logic [7:0]              drop_cnt,
`endif
    output logic                    overrun
);

    localparam int unsigned W  = $clog2(N_CH);
    localparam int unsigned CW = $clog2(PRESCALE);

    logic [1:0]      sync_q;
    logic            run;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0] prev_q, edges, clr, dup;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [0:0]      state_q, state_d;
    logic [W-1:0]    ch_q, ch_d, last_q, last_d, grant;
    logic            any, accept, overrun_q, overrun_d;

    // Two-stage release so the prescaler starts cleanly after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], 1'b1};
    end
    assign run = sync_q[1];

    always_comb begin
        update = enable && run && (cnt_q == CW'(PRESCALE - 1));
        cnt_d  = cnt_q;
        if (!enable)     cnt_d = '0;
        else if (update) cnt_d = '0;
        else if (run)    cnt_d = cnt_q + 1'b1;
    end

    rr_picker #(.N_CH(N_CH), .W(W)) u_picker (
        .pending_i (pending_q),
        .last_i    (last_q),
        .grant_o   (grant),
        .any_o     (any)
    );

    always_comb begin
        accept = (state_q == ST_OFFER) && evt_ready;
        edges  = update ? (level & ~prev_q) : '0;
        clr    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            clr[i] = accept && (ch_q == W'(i));
        end
        dup       = edges & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | edges;
        overrun_d = (|dup) ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            if (any) begin
                ch_d    = grant;
                state_d = ST_OFFER;
            end
        end else if (evt_ready) begin
            last_d  = ch_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            prev_q    <= '1;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            last_q    <= W'(N_CH - 1);
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            if (update) prev_q <= level;
            pending_q <= pending_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef BUTTON_EVENT_DROP_CNT_EN
    logic [7:0] drop_q;

    // A clear coinciding with a fresh drop leaves the count at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        drop_q <= '0;
        else if (ovr_clr)                  drop_q <= {7'b0, |dup};
        else if ((|dup) && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
    assign drop_cnt = drop_q;
`endif

    assign evt_valid = (state_q == ST_OFFER);
    assign evt_ch    = ch_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/button_event_scheduler.md
BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of level channels; legal range 2..16.
REQ-002 Parameter PRESCALE, default 1000, sample period in clk cycles; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 enable  input  1  1 = prescaler runs; 0 = prescaler held at 0, no sampling.
REQ-006 level  input  N_CH  raw channel levels, assumed already synchronised to clk.
REQ-007 update  output  1  one-cycle sample strobe.
REQ-008 evt_valid  output  1  event offered to the consumer.
REQ-009 evt_ch  output  $clog2(N_CH)  channel index of the offered event.
REQ-010 evt_ready  input  1  consumer accepts the offered event.
REQ-011 pending  output  N_CH  per-channel "rising edge not yet accepted" flags.
REQ-012 ovr_clr  input  1  synchronous clear of overrun.
REQ-013 overrun  output  1  sticky flag: a rising edge arrived on an already-pending channel.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 while enable=1 and wrap to 0; update=1 exactly in the cycle the count equals PRESCALE-1.
REQ-015 enable=0 SHALL force the count to 0 in the next cycle and keep update=0.
REQ-016 On an update cycle, the block SHALL register level into prev[N_CH]; edge[i] = update & level[i] & ~prev[i], all other cycles edge=0.
REQ-017 edge[i]=1 SHALL set pending[i] at the next clock edge.
REQ-018 edge[i]=1 while pending[i]=1 and pending[i] is not being cleared that cycle SHALL set overrun; the duplicate is dropped and pending[i] stays 1.
REQ-019 Arbiter FSM states: IDLE, OFFER.
REQ-020 IDLE: if pending is non-zero, grant the lowest pending index at or after (last+1) mod N_CH, circularly; register it into evt_ch; go to OFFER. evt_valid=0 in IDLE.
REQ-021 OFFER: evt_valid=1; evt_ch stable; on evt_ready=1, clear pending[evt_ch], set last=evt_ch, return to IDLE. Throughput: at most one event per 2 cycles.
REQ-022 evt_ready while evt_valid=0 SHALL be ignored.
REQ-023 Acceptance and a new edge on the same channel in the same cycle: the edge wins; pending stays 1; overrun is not set.
REQ-024 ovr_clr=1 SHALL clear overrun next cycle, unless a new overrun condition occurs in that same cycle, which wins.
REQ-025 pending SHALL include the channel currently offered.

Reset
REQ-026 Asserted reset SHALL immediately force: count=0, update=0, prev=all ones, pending=0, state=IDLE, evt_valid=0, evt_ch=0, last=N_CH-1, overrun=0.
REQ-027 Reset mid-OFFER SHALL drop the offered event without an acceptance.
REQ-028 Because prev resets to all ones, a channel reports its first edge only after a sample at 0 followed by a sample at 1.
REQ-029 Release SHALL be synchronised: the first count increment is two cycles after reset deasserts.

Configuration
REQ-030 Macro BUTTON_EVENT_DROP_CNT_EN defined: adds output drop_cnt [7:0], incremented on every dropped duplicate edge, saturating at 255, cleared by reset and by ovr_clr. The counter adds at most 1 per cycle, even when several channels drop in the same cycle.
REQ-031 Macro undefined: no drop_cnt port or logic; all other behaviour is identical.

Structure
REQ-032 Shared package button_event_pkg SHALL hold the FSM state encoding (IDLE, OFFER) and the default constants for N_CH and PRESCALE.
REQ-033 Sub-module rr_picker (combinational: pending vector and last index in, grant index and any flag out) SHALL implement the circular priority search.

Verification
REQ-034 PRESCALE=4, enable=1 after reset -> update high on cycles 4, 8, 12 after the reset release counts start, and never on other cycles.
REQ-035 level[2] sampled 0 then 1 -> pending=4'b0100, evt_valid=1 with evt_ch=2 one cycle later; evt_ready=1 -> pending=0, evt_valid=0.
REQ-036 Edges on channels 0, 1 and 3 in one update, last=0, evt_ready held 1 -> evt_ch sequence 1, 3, 0, each two cycles apart.
REQ-037 Second edge on channel 1 while pending[1]=1 and unaccepted -> overrun=1 and, with the macro defined, drop_cnt=1; ovr_clr=1 -> overrun=0 and drop_cnt=0.
REQ-038 Edge on the offered channel in the acceptance cycle -> pending bit stays 1, overrun=0, and the same channel is offered again.
REQ-039 reset asserted during OFFER with pending=4'b1010 -> evt_valid=0 and pending=0 immediately; no event is offered until new edges are sampled.
